vedic_mul_pipe: RTL and testbench

Parametrised, pipelined Urdhva-Tiryakbhyam multiplier. It accepts one WIDTH x WIDTH operation per cycle over a valid/ready handshake and supports four RISC-V-style result modes: MUL, MULH, MULHU and MULSU. Results emerge in order after a fixed three-stage latency, with full backpressure. It sits between the vector-lane operand fetch and the writeback path, and replaces the fixed-width combinational vedic tree for lanes that need registered timing.

---
 rtl/vedic_mul_pipe.sv | 171 +++++++++++++++++
 tb/tb_vedic_mul_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined Urdhva-Tiryakbhyam multiplier with valid/ready handshake
// and RISC-V style MUL/MULH/MULHU/MULSU result selection.

// Recursive vedic multiplier. The leaf is a 2x2 cell. Each level above it splits
// the operands into halves and merges the four sub-products with a carry-save
// stage followed by a single carry-propagate add.
module vedic_mul #(
  parameter int N = 2
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N == 2) begin : g_leaf
    logic t1, c1, hh;
    assign t1 = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1 = (a[1] & b[0]) & (a[0] & b[1]);
    assign hh = a[1] & b[1];
    assign p  = {hh & c1, hh ^ c1, t1, a[0] & b[0]};
  end else begin : g_split
    localparam int M = N / 2;

    logic [N-1:0]   ll, lh, hl, hh;
    logic [2*N-1:0] x, y, z, s, c;
    logic [2*N-2:0] maj;

    vedic_mul #(.N(M)) u_ll (.a(a[M-1:0]), .b(b[M-1:0]), .p(ll));
    vedic_mul #(.N(M)) u_lh (.a(a[M-1:0]), .b(b[N-1:M]), .p(lh));
    vedic_mul #(.N(M)) u_hl (.a(a[N-1:M]), .b(b[M-1:0]), .p(hl));
    vedic_mul #(.N(M)) u_hh (.a(a[N-1:M]), .b(b[N-1:M]), .p(hh));

    // HH and LL occupy disjoint bit ranges, so they share one CSA input.
    assign x   = {hh, ll};
    assign y   = {{M{1'b0}}, lh, {M{1'b0}}};
    assign z   = {{M{1'b0}}, hl, {M{1'b0}}};
    assign s   = x ^ y ^ z;
    assign maj = (x[2*N-2:0] & y[2*N-2:0]) | (x[2*N-2:0] & z[2*N-2:0]) |
                 (y[2*N-2:0] & z[2*N-2:0]);
    assign c   = {maj, 1'b0};
    assign p   = s + c;
  end

endmodule

module vedic_mul_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_MULSU = 2'b11
  } op_e;

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  // A stage may load when it is empty or when its successor frees it this cycle.
  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  // S1: sign/magnitude conversion.
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sa    = 1'b0;
    sb    = 1'b0;
    a_mag = in_a;
    b_mag = in_b;
    if (op_e'(in_op) == OP_MULH || op_e'(in_op) == OP_MULSU) sa = in_a[WIDTH-1];
    if (op_e'(in_op) == OP_MULH)                             sb = in_b[WIDTH-1];
    if (sa) a_mag = ~in_a + ONE_W;
    if (sb) b_mag = ~in_b + ONE_W;
  end

  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_neg;
  op_e              s1_op;
  logic [TAG_W-1:0] s1_tag;

  // S2: four half-width partial products.
  logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  vedic_mul #(.N(H)) u_pp_ll (.a(s1_a[H-1:0]),     .b(s1_b[H-1:0]),     .p(pp_ll));
  vedic_mul #(.N(H)) u_pp_lh (.a(s1_a[H-1:0]),     .b(s1_b[WIDTH-1:H]), .p(pp_lh));
  vedic_mul #(.N(H)) u_pp_hl (.a(s1_a[WIDTH-1:H]), .b(s1_b[H-1:0]),     .p(pp_hl));
  vedic_mul #(.N(H)) u_pp_hh (.a(s1_a[WIDTH-1:H]), .b(s1_b[WIDTH-1:H]), .p(pp_hh));

  logic [WIDTH-1:0] s2_ll, s2_lh, s2_hl, s2_hh;
  logic             s2_neg;
  op_e              s2_op;
  logic [TAG_W-1:0] s2_tag;

  // S3: full-width combine, sign restore and half select.
  logic [WIDTH:0]     mid;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   result;

  always_comb begin
    mid    = {1'b0, s2_lh} + {1'b0, s2_hl};
    prod   = {s2_hh, s2_ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
    prod_s = s2_neg ? (~prod + ONE_2W) : prod;
    result = (s2_op == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_a   <= a_mag;
      s1_b   <= b_mag;
      s1_neg <= sa ^ sb;
      s1_op  <= op_e'(in_op);
      s1_tag <= in_tag;
    end
    if (ld2 && v1) begin
      s2_ll  <= pp_ll;
      s2_lh  <= pp_lh;
      s2_hl  <= pp_hl;
      s2_hh  <= pp_hh;
      s2_neg <= s1_neg;
      s2_op  <= s1_op;
      s2_tag <= s1_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      // Output registers only change on a real beat, which keeps them stable under stall.
      if (ld3 && v2) begin
        out_result <= result;
        out_tag    <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Self-checking bench for vedic_mul_pipe: scoreboard against a direct-multiply
// model, directed corner products, backpressure, mid-stream reset and random traffic.
module tb_vedic_mul_pipe;

  localparam int W  = 16;
  localparam int TW = 4;
  localparam int N_RAND = 10000;

  logic          clk, rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  vedic_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: extend each operand per its signedness and multiply directly.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    logic [2*W+1:0] xa, xb, p;
    logic a_signed, b_signed;
    a_signed = (op == 2'b01) || (op == 2'b11);
    b_signed = (op == 2'b01);
    xa = {{(W+2){a_signed & a[W-1]}}, a};
    xb = {{(W+2){b_signed & b[W-1]}}, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          sb[$];
  int            n_acc = 0;
  int            n_out = 0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_res;
  logic [TW-1:0] prev_tag;

  // Compare process: handshakes are sampled mid-cycle, where they equal what the next edge sees.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid",  64'(out_valid),  64'(1));
        check("hold_result", 64'(out_result), 64'(prev_res));
        check("hold_tag",    64'(out_tag),    64'(prev_tag));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("spurious_out", 64'(sb.size()), 64'(1));
        end else begin
          e = sb.pop_front();
          check("out_result", 64'(out_result), 64'(e.res));
          check("out_tag",    64'(out_tag),    64'(e.tag));
        end
      end
      if (in_valid && in_ready) begin
        e.res = model(in_a, in_b, in_op);
        e.tag = in_tag;
        sb.push_back(e);
        n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_tag   = out_tag;
    end
  end

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic [TW-1:0] tag);
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i == 200) begin
        check("send_timeout", 64'(in_ready), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic [W-1:0] exp);
    out_ready = 1'b1;
    send(a, b, op, 4'h9);
    repeat (2) @(negedge clk);
    check({name, "_early"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check(name, 64'(out_result), 64'(exp));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc, cyc, stale, out_before, start;
    logic [TW-1:0] tag;
    logic took;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_in_ready",   64'(in_ready),   64'(1));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_out_tag",    64'(out_tag),    64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Hand-computed corner products, each also checking the three-edge latency.
    lat_check("mulhu_ffff", 16'hFFFF, 16'hFFFF, 2'b10, 16'hFFFE);
    lat_check("mul_ffff",   16'hFFFF, 16'hFFFF, 2'b00, 16'h0001);
    lat_check("mulh_8000",  16'h8000, 16'h8000, 2'b01, 16'h4000);
    lat_check("mulh_ffff",  16'hFFFF, 16'hFFFF, 2'b01, 16'h0000);
    lat_check("mulsu_ffff", 16'hFFFF, 16'hFFFF, 2'b11, 16'hFFFF);
    lat_check("mulsu_8000", 16'h8000, 16'h0002, 2'b11, 16'hFFFF);
    lat_check("mul_1234",   16'h1234, 16'h5678, 2'b00, 16'h0060);
    drain("directed_drain");

    // Backpressure: tags 1..5 offered back to back with the consumer stalled.
    out_ready  = 1'b0;
    out_before = n_out;
    acc = 0; cyc = 0; tag = 4'd1;
    in_a = rand_operand(); in_b = rand_operand(); in_op = 2'($urandom); in_tag = tag;
    in_valid = 1'b1;
    while (acc < 5 && cyc < 100) begin
      @(negedge clk);
      took = in_ready;
      if (acc == 3 && cyc < 8) check("bp_ready_low", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      if (took) begin
        acc++; tag++;
        in_a = rand_operand(); in_b = rand_operand(); in_op = 2'($urandom); in_tag = tag;
      end
      cyc++;
      if (cyc == 8) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_accepts", 64'(acc), 64'(5));
    drain("bp_drain");
    check("bp_out_count", 64'(n_out - out_before), 64'(5));

    // Mid-stream reset with the pipeline full.
    out_ready = 1'b0;
    send(16'h0003, 16'h0005, 2'b00, 4'h1);
    send(16'h0007, 16'h0009, 2'b10, 4'h2);
    send(16'h8001, 16'h7FFF, 2'b01, 4'h3);
    @(negedge clk);
    check("rs_full", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rs_out_valid",  64'(out_valid),  64'(0));
    check("rs_in_ready",   64'(in_ready),   64'(1));
    check("rs_out_result", 64'(out_result), 64'(0));
    check("rs_out_tag",    64'(out_tag),    64'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rs_no_stale", 64'(stale), 64'(0));
    @(posedge clk); #1;

    // Random traffic on both sides of the handshake.
    start = n_acc; cyc = 0;
    while (n_acc - start < N_RAND && cyc < 60000) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_a     = rand_operand();
        in_b     = rand_operand();
        in_op    = 2'($urandom);
        in_tag   = TW'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_beats", 64'(n_acc - start), 64'(N_RAND));
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
